// File: rtl/mycpu_load_wb_pkg.sv
// Shared constants and types for the load writeback stage: ld_mode encoding,
// register-number width and the latched pipeline entry.
package mycpu_load_wb_pkg;
  localparam int REG_W = 5;

  localparam logic [2:0] LD_LB   = 3'b000;
  localparam logic [2:0] LD_LBU  = 3'b001;
  localparam logic [2:0] LD_LH   = 3'b010;
  localparam logic [2:0] LD_LHU  = 3'b011;
  localparam logic [2:0] LD_LW   = 3'b100;
  localparam logic [2:0] LD_LWL  = 3'b101;
  localparam logic [2:0] LD_LWR  = 3'b110;
  localparam logic [2:0] LD_NONE = 3'b111;

  typedef struct packed {
    logic [31:0]      pc;
    logic [2:0]       ldMode;
    logic [1:0]       addrLow2;
    logic [31:0]      rtOld;
    logic [31:0]      result;
    logic [REG_W-1:0] dest;
    logic             wrEn;
  } wsEntry_t;
endpackage

// File: rtl/mycpu_load_wb_if.sv
// MEM -> WB handshake and instruction payload.
interface mycpu_load_wb_if;
  import mycpu_load_wb_pkg::*;

  logic             ms_to_ws_valid;
  logic             ws_allowin;
  logic [31:0]      ms_pc;
  logic [2:0]       ms_ld_mode;
  logic [1:0]       ms_addr_low2;
  logic [31:0]      ms_rt_old;
  logic [31:0]      ms_result;
  logic [REG_W-1:0] ms_dest;
  logic             ms_wr_en;

  modport master (
    output ms_to_ws_valid, ms_pc, ms_ld_mode, ms_addr_low2, ms_rt_old,
           ms_result, ms_dest, ms_wr_en,
    input  ws_allowin
  );

  modport slave (
    input  ms_to_ws_valid, ms_pc, ms_ld_mode, ms_addr_low2, ms_rt_old,
           ms_result, ms_dest, ms_wr_en,
    output ws_allowin
  );
endinterface

// File: rtl/mycpu_load_align.sv
// Load data alignment: picks and extends the addressed lanes of the read word,
// and merges LWL/LWR with the old rt (inverse of the SWL/SWR lane placement).
module mycpu_load_align
  import mycpu_load_wb_pkg::*;
(
  input  logic [2:0]  ld_mode,
  input  logic [1:0]  addr_low2,
  input  logic [31:0] rdata,
  input  logic [31:0] rt_old,
  output logic [31:0] value
);
  logic [7:0]  byteSel;
  logic [15:0] halfSel;

  assign byteSel = 8'(rdata >> {addr_low2, 3'b000});
  // addr_low2[0] ignored for halves; misalignment is trapped upstream
  assign halfSel = addr_low2[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    value = rdata;
    case (ld_mode)
      LD_LB:  value = {{24{byteSel[7]}}, byteSel};
      LD_LBU: value = {24'h0, byteSel};
      LD_LH:  value = {{16{halfSel[15]}}, halfSel};
      LD_LHU: value = {16'h0, halfSel};
      LD_LWL: begin
        case (addr_low2)
          2'd0:    value = {rdata[7:0],  rt_old[23:0]};
          2'd1:    value = {rdata[15:0], rt_old[15:0]};
          2'd2:    value = {rdata[23:0], rt_old[7:0]};
          default: value = rdata;
        endcase
      end
      LD_LWR: begin
        case (addr_low2)
          2'd0:    value = rdata;
          2'd1:    value = {rt_old[31:24], rdata[31:8]};
          2'd2:    value = {rt_old[31:16], rdata[31:16]};
          default: value = {rt_old[31:8],  rdata[31:24]};
        endcase
      end
      default: value = rdata;
    endcase
  end
endmodule

// File: rtl/mycpu_load_wb.sv
// Writeback stage: one pipeline register, a hold buffer that keeps the SRAM
// word alive across stalls, and register-file / trace output logic.
module mycpu_load_wb
  import mycpu_load_wb_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  mycpu_load_wb_if.slave   ms,
  input  logic [31:0]      data_sram_rdata,
  input  logic             ws_stall,
  output logic             rf_we,
  output logic [REG_W-1:0] rf_waddr,
  output logic [31:0]      rf_wdata,
  output logic [REG_W-1:0] ws_fwd_dest,
  output logic [31:0]      debug_wb_pc,
  output logic [3:0]       debug_wb_rf_wen,
  output logic [REG_W-1:0] debug_wb_rf_wnum,
  output logic [31:0]      debug_wb_rf_wdata
);
  wsEntry_t    ws;
  logic        ws_valid;
  logic        ws_ready_go;
  logic        held;
  logic [31:0] rdata_hold;
  logic [31:0] rdataEff;
  logic [31:0] loadValue;
  logic        accept;

  assign ws_ready_go   = !ws_stall;
  assign ms.ws_allowin = !ws_valid || ws_ready_go;
  assign accept        = ms.ms_to_ws_valid && ms.ws_allowin;

  always_ff @(posedge clk) begin
    if (reset) begin
      ws_valid   <= 1'b0;
      ws         <= '{ldMode: LD_NONE, default: '0};
      held       <= 1'b0;
      rdata_hold <= 32'h0;
    end else if (accept) begin
      ws_valid <= 1'b1;
      ws       <= '{pc: ms.ms_pc, ldMode: ms.ms_ld_mode, addrLow2: ms.ms_addr_low2,
                    rtOld: ms.ms_rt_old, result: ms.ms_result, dest: ms.ms_dest,
                    wrEn: ms.ms_wr_en};
      held     <= 1'b0;
    end else if (ws_ready_go) begin
      ws_valid <= 1'b0;
      held     <= 1'b0;
    end else if (ws_valid && !held && ws.ldMode != LD_NONE) begin
      // SRAM data is only valid in the entry's first cycle; freeze it here
      held       <= 1'b1;
      rdata_hold <= data_sram_rdata;
    end
  end

  assign rdataEff = held ? rdata_hold : data_sram_rdata;

  mycpu_load_align uAlign (
    .ld_mode   (ws.ldMode),
    .addr_low2 (ws.addrLow2),
    .rdata     (rdataEff),
    .rt_old    (ws.rtOld),
    .value     (loadValue)
  );

  assign rf_we       = ws_valid && ws_ready_go && ws.wrEn && (ws.dest != '0);
  assign rf_waddr    = ws.dest;
  assign rf_wdata    = (ws.ldMode != LD_NONE) ? loadValue : ws.result;
  assign ws_fwd_dest = (ws_valid && ws.wrEn) ? ws.dest : '0;

  assign debug_wb_pc       = ws.pc;
  assign debug_wb_rf_wen   = {4{rf_we}};
  assign debug_wb_rf_wnum  = rf_waddr;
  assign debug_wb_rf_wdata = rf_wdata;
endmodule

// File: tb/tb_mycpu_load_wb.sv
// Directed bench for mycpu_load_wb: alignment vectors, stall/hold, streaming,
// dest=0 and reset during a stall.
module tb_mycpu_load_wb;
  import mycpu_load_wb_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] data_sram_rdata;
  logic        ws_stall;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [4:0]  ws_fwd_dest;
  logic [31:0] debug_wb_pc;
  logic [3:0]  debug_wb_rf_wen;
  logic [4:0]  debug_wb_rf_wnum;
  logic [31:0] debug_wb_rf_wdata;
  int          errors = 0;
  int          checks = 0;

  mycpu_load_wb_if msIf ();

  mycpu_load_wb dut (
    .clk               (clk),
    .reset             (reset),
    .ms                (msIf.slave),
    .data_sram_rdata   (data_sram_rdata),
    .ws_stall          (ws_stall),
    .rf_we             (rf_we),
    .rf_waddr          (rf_waddr),
    .rf_wdata          (rf_wdata),
    .ws_fwd_dest       (ws_fwd_dest),
    .debug_wb_pc       (debug_wb_pc),
    .debug_wb_rf_wen   (debug_wb_rf_wen),
    .debug_wb_rf_wnum  (debug_wb_rf_wnum),
    .debug_wb_rf_wdata (debug_wb_rf_wdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic offer(input logic [31:0] pc, input logic [2:0] mode, input logic [1:0] a,
                       input logic [31:0] rt, input logic [31:0] res, input logic [4:0] dest,
                       input logic wrEn);
    msIf.ms_to_ws_valid = 1'b1;
    msIf.ms_pc          = pc;
    msIf.ms_ld_mode     = mode;
    msIf.ms_addr_low2   = a;
    msIf.ms_rt_old      = rt;
    msIf.ms_result      = res;
    msIf.ms_dest        = dest;
    msIf.ms_wr_en       = wrEn;
  endtask

  // Accept one instruction, present SRAM data in its first cycle, check at negedge
  task automatic oneLoad(input string tag, input logic [2:0] mode, input logic [1:0] a,
                         input logic [31:0] rdata, input logic [31:0] rt,
                         input logic [31:0] exp);
    offer(32'hBFC0_0000, mode, a, rt, 32'h5555_5555, 5'd9, 1'b1);
    @(posedge clk); #1;
    msIf.ms_to_ws_valid = 1'b0;
    data_sram_rdata     = rdata;
    @(negedge clk);
    chk({tag, "_we"}, 32'(rf_we), 32'd1);
    chk({tag, "_wdata"}, rf_wdata, exp);
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    ws_stall = 1'b0;
    data_sram_rdata = 32'h0;
    offer(32'h0, LD_NONE, 2'd0, 32'h0, 32'h0, 5'd0, 1'b0);
    msIf.ms_to_ws_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_we", 32'(rf_we), 32'd0);
    chk("rst_fwd", 32'(ws_fwd_dest), 32'd0);
    chk("rst_wen", 32'(debug_wb_rf_wen), 32'd0);
    chk("rst_allowin", 32'(msIf.ws_allowin), 32'd1);
    @(posedge clk); #1;

    // alignment vectors
    oneLoad("lb3",   LD_LB,   2'd3, 32'h80FF_1234, 32'h0,          32'hFFFF_FF80);
    oneLoad("lbu3",  LD_LBU,  2'd3, 32'h80FF_1234, 32'h0,          32'h0000_0080);
    oneLoad("lb1",   LD_LB,   2'd1, 32'h80FF_1234, 32'h0,          32'h0000_0012);
    oneLoad("lwl1",  LD_LWL,  2'd1, 32'hAABB_CCDD, 32'h1122_3344,  32'hCCDD_3344);
    oneLoad("lwr1",  LD_LWR,  2'd1, 32'hAABB_CCDD, 32'h1122_3344,  32'h11AA_BBCC);
    oneLoad("lwl0",  LD_LWL,  2'd0, 32'hAABB_CCDD, 32'h1122_3344,  32'hDD22_3344);
    oneLoad("lwr3",  LD_LWR,  2'd3, 32'hAABB_CCDD, 32'h1122_3344,  32'h1122_33AA);
    oneLoad("lh2",   LD_LH,   2'd2, 32'h8001_7FFF, 32'h0,          32'hFFFF_8001);
    oneLoad("lhu1",  LD_LHU,  2'd1, 32'h8001_7FFF, 32'h0,          32'h0000_7FFF);
    oneLoad("lw2",   LD_LW,   2'd2, 32'h1357_9BDF, 32'h0,          32'h1357_9BDF);
    oneLoad("none",  LD_NONE, 2'd2, 32'h1357_9BDF, 32'h0,          32'h5555_5555);

    // stall with SRAM data going stale after the first cycle
    ws_stall = 1'b1;
    offer(32'hBFC0_0040, LD_LW, 2'd0, 32'h0, 32'h0, 5'd7, 1'b1);
    @(posedge clk); #1;
    msIf.ms_to_ws_valid = 1'b0;
    data_sram_rdata = 32'hDEAD_BEEF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("stall%0d_we", i), 32'(rf_we), 32'd0);
      chk($sformatf("stall%0d_fwd", i), 32'(ws_fwd_dest), 32'd7);
      chk($sformatf("stall%0d_allowin", i), 32'(msIf.ws_allowin), 32'd0);
      @(posedge clk); #1;
      data_sram_rdata = 32'h0BAD_0BAD + i;
    end
    ws_stall = 1'b0;
    @(negedge clk);
    chk("release_we", 32'(rf_we), 32'd1);
    chk("release_wdata", rf_wdata, 32'hDEAD_BEEF);
    chk("release_waddr", 32'(rf_waddr), 32'd7);
    @(posedge clk); #1;
    @(negedge clk);
    chk("after_release_we", 32'(rf_we), 32'd0);
    chk("after_release_held", 32'(dut.held), 32'd0);
    @(posedge clk); #1;

    // back-to-back stream of four loads
    offer(32'hBFC0_0100, LD_LW, 2'd0, 32'h0, 32'h0, 5'd1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (i < 3) offer(32'hBFC0_0104 + 4 * i, LD_LW, 2'd0, 32'h0, 32'h0, 5'(i + 2), 1'b1);
      else msIf.ms_to_ws_valid = 1'b0;
      data_sram_rdata = 32'h1111_1111 * (i + 1);
      @(negedge clk);
      chk($sformatf("b2b%0d_we", i), 32'(rf_we), 32'd1);
      chk($sformatf("b2b%0d_waddr", i), 32'(rf_waddr), 32'(i + 1));
      chk($sformatf("b2b%0d_wdata", i), rf_wdata, 32'h1111_1111 * (i + 1));
      chk($sformatf("b2b%0d_allowin", i), 32'(msIf.ws_allowin), 32'd1);
      chk($sformatf("b2b%0d_held", i), 32'(dut.held), 32'd0);
    end
    @(posedge clk); #1;

    // dest = 0: presented on trace but no write
    offer(32'hBFC0_0200, LD_NONE, 2'd0, 32'h0, 32'h1234_5678, 5'd0, 1'b1);
    @(posedge clk); #1;
    msIf.ms_to_ws_valid = 1'b0;
    @(negedge clk);
    chk("d0_we", 32'(rf_we), 32'd0);
    chk("d0_wen", 32'(debug_wb_rf_wen), 32'd0);
    chk("d0_pc", debug_wb_pc, 32'hBFC0_0200);
    @(posedge clk); #1;

    // reset in the middle of a stalled load
    ws_stall = 1'b1;
    offer(32'hBFC0_0300, LD_LW, 2'd0, 32'h0, 32'h0, 5'd12, 1'b1);
    @(posedge clk); #1;
    msIf.ms_to_ws_valid = 1'b0;
    data_sram_rdata = 32'hCAFE_F00D;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rstall_fwd", 32'(ws_fwd_dest), 32'd12);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rstall_allowin", 32'(msIf.ws_allowin), 32'd1);
    chk("rstall_fwd0", 32'(ws_fwd_dest), 32'd0);
    ws_stall = 1'b0;
    #1;
    chk("rstall_we", 32'(rf_we), 32'd0);
    @(posedge clk); #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
